// File: rtl/qed_i_cache.sv
// rtl/qed_i_cache.sv - QED instruction buffer: records fetched instructions, then replays them for duplication
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ena                      QED enable; low = pure pass-through with the buffer cleared
//   exec_dup                 request an early switch to replay (DUP) mode
//   stall_IF                 downstream stall; outputs, pointers, count and mode hold
//   ifu_instruction/ifu_vld  fetched instruction and its valid
//   ifu_ready                combinational accept indication back to the IFU
//   qic_qimux_instruction    registered instruction to the decode/modify stage
//   qic_vld                  registered valid for qic_qimux_instruction
//   qed_mode                 0 = ORIG (record), 1 = DUP (replay)
//   buf_count/full/empty     buffer occupancy
module qed_i_cache #(
    parameter int          DEPTH  = 16,
    parameter int          ADDR_W = 4,
    parameter logic [31:0] NOP    = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              exec_dup,
    input  logic              stall_IF,
    input  logic [31:0]       ifu_instruction,
    input  logic              ifu_vld,
    output logic              ifu_ready,
    output logic [31:0]       qic_qimux_instruction,
    output logic              qic_vld,
    output logic              qed_mode,
    output logic [ADDR_W:0]   buf_count,
    output logic              buf_full,
    output logic              buf_empty
);

    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

    typedef enum logic {
        ORIG = 1'b0,
        DUP  = 1'b1
    } mode_t;

    mode_t              state;
    mode_t              state_next;
    logic [31:0]        mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    count_next;
    logic               push;
    logic               pop;

    // Push only happens in ORIG and pop only in DUP, so they never coincide.
    assign push = ena && (state == ORIG) && ifu_vld && ifu_ready;
    assign pop  = ena && (state == DUP) && !stall_IF && (buf_count != '0);

    always_comb begin
        count_next = buf_count;
        if (!ena) begin
            count_next = '0;
        end else if (push) begin
            count_next = buf_count + {{ADDR_W{1'b0}}, 1'b1};
        end else if (pop) begin
            count_next = buf_count - {{ADDR_W{1'b0}}, 1'b1};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ORIG;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Mode decisions look at the post-update count so the
    // push that fills the last entry, or the exec_dup that arrives with the
    // final recorded push, switches to replay on the same edge.
    always_comb begin
        state_next = state;
        if (!ena) begin
            state_next = ORIG;
        end else if (!stall_IF) begin
            case (state)
                ORIG: begin
                    if (count_next == FULL_CNT || (exec_dup && count_next != '0)) begin
                        state_next = DUP;
                    end
                end
                DUP: begin
                    if (count_next == '0) begin
                        state_next = ORIG;
                    end
                end
                default: state_next = ORIG;
            endcase
        end
    end

    // Output logic
    always_comb begin
        qed_mode  = (state == DUP);
        buf_full  = (buf_count == FULL_CNT);
        buf_empty = (buf_count == '0);
        ifu_ready = ena ? ((state == ORIG) && !buf_full && !stall_IF) : !stall_IF;
    end

    // Pointers and occupancy. Disabling QED discards the buffer even during a
    // stall; only the output registers honour the stall in that case.
    always_ff @(posedge clk) begin
        if (rst || !ena) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else begin
            buf_count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
        end
    end

    // Buffer storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= ifu_instruction;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qic_qimux_instruction <= NOP;
            qic_vld               <= 1'b0;
        end else if (!stall_IF) begin
            if (!ena) begin
                qic_qimux_instruction <= ifu_vld ? ifu_instruction : NOP;
                qic_vld               <= ifu_vld;
            end else if (push) begin
                qic_qimux_instruction <= ifu_instruction;
                qic_vld               <= 1'b1;
            end else if (pop) begin
                qic_qimux_instruction <= mem[rd_ptr];
                qic_vld               <= 1'b1;
            end else begin
                qic_qimux_instruction <= NOP;
                qic_vld               <= 1'b0;
            end
        end
    end

endmodule
